fsm_job_arbiter: RTL and testbench

Round-robin job scheduler that shares one worker FSM (fsm_rtl: level start in, busy/error out) among N_REQ requesters. It grants one requester at a time, drives the worker's start and abort, and supervises each job with a watchdog. Failed or timed-out jobs are retried a bounded number of times. The result goes back to the granted requester as a one-cycle ack or nak pulse.

---
 rtl/fsm_job_arbiter.sv | 177 +++++++++++++++++
 tb/tb_fsm_job_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_job_arbiter.sv
// Round-robin scheduler that shares one worker FSM among N_REQ requesters,
// supervising each attempt with a watchdog and retrying failed jobs.
module fsm_job_arbiter #(
    parameter int N_REQ     = 4,
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 200,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    // Requester handshake: i_req[n] is a level held until o_ack[n] or o_nak[n]
    // pulses for one cycle; that pulse ends the job, after which i_req[n] may
    // drop or stay high to queue another job. Requests are sampled in IDLE only.
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_gnt,
    output logic [N_REQ-1:0] o_ack,
    output logic [N_REQ-1:0] o_nak,
    output logic             o_wk_start,
    output logic             o_wk_abort,
    input  logic             i_wk_busy,
    input  logic             i_wk_error,
    output logic             o_timeout_evt,
    output logic             o_active,
    output logic [2:0]       o_dbg_state,
    output logic [2:0]       o_dbg_retry
);

    localparam int IW = $clog2(N_REQ);
    localparam int SW = IW + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_RUN    = 3'd2,
        S_DONE   = 3'd3,
        S_ABORT  = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [IW-1:0]        r_gidx;
    logic [IW-1:0]        w_gidx_nxt;
    logic [IW-1:0]        r_rr_ptr;
    logic [IW-1:0]        w_rr_nxt;
    logic [TIMEOUT_W-1:0] r_timer;
    logic [TIMEOUT_W-1:0] w_timer_nxt;
    logic [2:0]           r_retry;
    logic [2:0]           w_retry_nxt;
    logic [N_REQ-1:0]     r_nak;
    logic [N_REQ-1:0]     w_nak_nxt;
    logic                 r_tevt;
    logic                 w_tevt_nxt;

    logic [IW-1:0]        w_pick;
    logic                 w_pick_vld;
    logic [SW-1:0]        w_cand;
    logic                 w_timer_last;

    function automatic logic [IW-1:0] f_next_idx(input logic [IW-1:0] idx);
        if (idx == IW'(N_REQ - 1)) return '0;
        return idx + 1'b1;
    endfunction

    // First set request at or above the round-robin pointer, wrapping once.
    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        w_cand     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = {1'b0, r_rr_ptr} + SW'(i);
            if (w_cand >= SW'(N_REQ)) w_cand = w_cand - SW'(N_REQ);
            if (!w_pick_vld && i_req[w_cand[IW-1:0]]) begin
                w_pick     = w_cand[IW-1:0];
                w_pick_vld = 1'b1;
            end
        end
    end

    assign w_timer_last = (r_timer == TIMEOUT_W'(TIMEOUT - 1));

    always_comb begin
        w_next      = r_state;
        w_gidx_nxt  = r_gidx;
        w_rr_nxt    = r_rr_ptr;
        w_timer_nxt = r_timer;
        w_retry_nxt = r_retry;
        w_nak_nxt   = '0;
        w_tevt_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld && !i_wk_error) begin
                    w_gidx_nxt  = w_pick;
                    w_retry_nxt = '0;
                    w_timer_nxt = '0;
                    w_next      = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_timer_nxt = r_timer + 1'b1;
                if (i_wk_error)        w_next = S_FAIL;
                else if (i_wk_busy)    w_next = S_RUN;
                else if (w_timer_last) w_next = S_ABORT;
            end
            S_RUN: begin
                w_timer_nxt = r_timer + 1'b1;
                if (i_wk_error)        w_next = S_FAIL;
                else if (!i_wk_busy)   w_next = S_DONE;
                else if (w_timer_last) w_next = S_ABORT;
            end
            S_DONE: begin
                w_rr_nxt = f_next_idx(r_gidx);
                w_next   = S_IDLE;
            end
            S_ABORT: begin
                if (i_wk_error) w_next = S_FAIL;
            end
            S_FAIL: begin
                // Relaunch only once the worker has dropped its error and is idle again.
                if (!i_wk_error) begin
                    if (r_retry < 3'(MAX_RETRY)) begin
                        w_retry_nxt = r_retry + 1'b1;
                        w_timer_nxt = '0;
                        w_next      = S_LAUNCH;
                    end else begin
                        w_nak_nxt[r_gidx] = 1'b1;
                        w_rr_nxt          = f_next_idx(r_gidx);
                        w_next            = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
        w_tevt_nxt = (w_next == S_ABORT) && (r_state != S_ABORT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_gidx   <= '0;
            r_rr_ptr <= '0;
            r_timer  <= '0;
            r_retry  <= '0;
            r_nak    <= '0;
            r_tevt   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_gidx   <= w_gidx_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_timer  <= w_timer_nxt;
            r_retry  <= w_retry_nxt;
            r_nak    <= w_nak_nxt;
            r_tevt   <= w_tevt_nxt;
        end
    end

    always_comb begin
        o_gnt = '0;
        o_ack = '0;
        if (r_state != S_IDLE) o_gnt[r_gidx] = 1'b1;
        if (r_state == S_DONE) o_ack[r_gidx] = 1'b1;
    end

    assign o_nak         = r_nak;
    assign o_wk_start    = (r_state == S_LAUNCH) || (r_state == S_RUN);
    assign o_wk_abort    = (r_state == S_ABORT);
    assign o_timeout_evt = r_tevt;
    assign o_active      = (r_state != S_IDLE);
    assign o_dbg_state   = r_state;
    assign o_dbg_retry   = r_retry;

    a_ack_nak_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !((|o_ack) && (|o_nak)));
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(o_gnt));

endmodule

// File: tb/tb_fsm_job_arbiter.sv
// Randomized bench for fsm_job_arbiter: a behavioural worker model, a job-level
// reference model that predicts ack/nak per job, and a decoupled scoreboard.
module tb_fsm_job_arbiter;

    localparam int N_REQ     = 4;
    localparam int TIMEOUT_W = 8;
    localparam int TIMEOUT   = 16;
    localparam int MAX_RETRY = 2;
    localparam int EW        = 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] ack;
    logic [N_REQ-1:0] nak;
    logic             wk_start;
    logic             wk_abort;
    logic             wk_busy;
    logic             wk_error;
    logic             worker_err;
    logic             ext_fault;
    logic             timeout_evt;
    logic             active;
    logic [2:0]       dbg_state;
    logic [2:0]       dbg_retry;

    assign wk_error = worker_err | ext_fault;

    always #5 clk = ~clk;

    fsm_job_arbiter #(
        .N_REQ(N_REQ), .TIMEOUT_W(TIMEOUT_W), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_req(req), .o_gnt(gnt), .o_ack(ack), .o_nak(nak),
        .o_wk_start(wk_start), .o_wk_abort(wk_abort), .i_wk_busy(wk_busy),
        .i_wk_error(wk_error), .o_timeout_evt(timeout_evt), .o_active(active),
        .o_dbg_state(dbg_state), .o_dbg_retry(dbg_retry)
    );

    int checks = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];   // {is_nak, idx[2:0], retry[2:0]}
    int beh_q[$];              // kind*16 + param; kind 0 ok, 1 error, 2 hang
    int rr_model = 0;
    int exp_timeouts = 0;
    int seen_timeouts = 0;

    function automatic void check(input string name, input bit ok, input longint act, input longint expv);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic int pick(input logic [N_REQ-1:0] m, input int rr);
        for (int i = 0; i < N_REQ; i++) begin
            int k;
            k = (rr + i) % N_REQ;
            if (((m >> k) & N_REQ'(1)) != 0) return k;
        end
        return 0;
    endfunction

    // One job: nfail failing attempts (fsel 0 error, 1 hang, 2 random), then success if retries remain.
    task automatic plan_job(input int idx, input int nfail, input int fsel, input int len);
        int kind;
        int par;
        for (int f = 0; f < nfail && f <= MAX_RETRY; f++) begin
            kind = (fsel == 2) ? int'($urandom_range(1, 2)) : fsel + 1;
            par  = (len > 0) ? len : int'($urandom_range(0, 5));
            if (kind == 2) begin
                exp_timeouts++;
                par = 0;
            end
            beh_q.push_back(kind * 16 + par);
        end
        if (nfail <= MAX_RETRY) begin
            par = (len > 0) ? len : int'($urandom_range(1, 8));
            beh_q.push_back(par);
            exp_q.push_back({1'b0, 3'(idx), 3'(nfail)});
        end else begin
            exp_q.push_back({1'b1, 3'(idx), 3'(MAX_RETRY)});
        end
        rr_model = (idx + 1) % N_REQ;
    endtask

    task automatic run_jobs(input int nres);
        int got;
        got = 0;
        for (int c = 0; c < 3000 && got < nres; c++) begin
            @(posedge clk);
            #2;
            if (ack != 0 || nak != 0) begin
                got++;
                if (got == nres) req = '0;
            end
        end
        check("job_budget", got == nres, got, nres);
        req = '0;
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic wait_grant(input string name);
        int c;
        c = 0;
        while (gnt == 0 && c < 100) begin
            @(posedge clk);
            #2;
            c++;
        end
        check(name, gnt != 0, gnt, 1);
    endtask

    // Worker model: samples arbiter outputs before the edge, updates 1 ns after it.
    int   w_state = 0;
    int   w_cnt = 0;
    int   w_kind = 0;
    int   w_par = 0;
    int   w_b = 0;
    logic s_start;
    logic s_abort;

    initial begin
        wk_busy = 1'b0;
        worker_err = 1'b0;
        forever begin
            @(negedge clk);
            s_start = wk_start;
            s_abort = wk_abort;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                w_state = 0; wk_busy = 1'b0; worker_err = 1'b0;
            end else begin
                case (w_state)
                    0: if (s_start) begin
                        if (beh_q.size() == 0) w_b = 1;
                        else w_b = beh_q.pop_front();
                        w_kind = w_b / 16;
                        w_par  = w_b % 16;
                        if (w_kind == 1 && w_par == 0) begin
                            w_state = 3; worker_err = 1'b1; w_cnt = $urandom_range(1, 3);
                        end else begin
                            w_state = 1; wk_busy = 1'b1; w_cnt = w_par;
                        end
                    end
                    1: if (w_kind == 2) begin
                        if (s_abort) begin
                            w_state = 3; wk_busy = 1'b0; worker_err = 1'b1; w_cnt = $urandom_range(1, 3);
                        end
                    end else begin
                        w_cnt--;
                        if (w_cnt <= 0) begin
                            wk_busy = 1'b0;
                            if (w_kind == 0) w_state = 2;
                            else begin
                                w_state = 3; worker_err = 1'b1; w_cnt = $urandom_range(1, 3);
                            end
                        end
                    end
                    2: if (!s_start) w_state = 0;
                    default: if (!s_start && !s_abort) begin
                        w_cnt--;
                        if (w_cnt <= 0) begin
                            w_state = 0; worker_err = 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: invariants every cycle, scoreboard pop on every ack/nak pulse.
    logic            p_abort = 1'b0;
    logic            p_err = 1'b0;
    logic            p_start = 1'b0;
    logic            p_busy = 1'b0;
    int              start_len = 0;
    logic [EW-1:0]   mon_e;
    logic [N_REQ-1:0] mon_v;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_abort = 1'b0; p_err = 1'b0; p_start = 1'b0; p_busy = 1'b0; start_len = 0;
        end else begin
            check("active_vs_gnt", active == (gnt != 0), active, gnt != 0);
            check("gnt_onehot", $countones(gnt) <= 1, $countones(gnt), 1);
            check("ack_nak_excl", !((ack != 0) && (nak != 0)), {ack, nak}, 0);
            if (p_abort && p_err) check("abort_drop", !wk_abort, wk_abort, 0);
            if (wk_start) start_len = p_start ? start_len + 1 : 1;
            if (timeout_evt) begin
                seen_timeouts++;
                check("timeout_len", start_len == TIMEOUT, start_len, TIMEOUT);
                check("timeout_with_abort", wk_abort, wk_abort, 1);
            end
            if (ack != 0) check("ack_after_busy_low", p_start && !p_busy, {p_start, p_busy}, 2);
            if (ack != 0 || nak != 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1'b0, {ack, nak}, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_v = N_REQ'(1) << mon_e[5:3];
                    if (mon_e[6]) begin
                        check("nak_vec", nak == mon_v && ack == 0, {ack, nak}, mon_v);
                        check("nak_gnt_low", gnt == 0, gnt, 0);
                    end else begin
                        check("ack_vec", ack == mon_v && nak == 0, {ack, nak}, {mon_v, 4'b0});
                        check("ack_gnt", gnt == mon_v, gnt, mon_v);
                    end
                    check("retry_count", dbg_retry == mon_e[2:0], dbg_retry, mon_e[2:0]);
                end
            end
            p_abort = wk_abort; p_err = wk_error; p_start = wk_start; p_busy = wk_busy;
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout actual=%0t required=finish", $time);
        $fatal(1, "bench time limit");
    end

    initial begin
        int nj;
        logic [N_REQ-1:0] m;
        req = '0;
        ext_fault = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_gnt", gnt == 0, gnt, 0);
        check("rst_ack_nak", ack == 0 && nak == 0, {ack, nak}, 0);
        check("rst_ctrl", {wk_start, wk_abort, timeout_evt, active} == 0, {wk_start, wk_abort, timeout_evt, active}, 0);
        check("rst_retry", dbg_retry == 0, dbg_retry, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("idle_gnt", gnt == 0 && !active, {gnt, active}, 0);

        // Single job, worker done 5 cycles after busy.
        plan_job(pick(4'b0001, rr_model), 0, 0, 5);
        req = 4'b0001;
        run_jobs(1);

        // Held multi-request: six successful jobs in round-robin order with wrap.
        for (int j = 0; j < 6; j++) plan_job(pick(4'b1011, rr_model), 0, 0, 0);
        req = 4'b1011;
        run_jobs(6);

        // Error on first attempt, clean retry.
        plan_job(pick(4'b0100, rr_model), 1, 0, 3);
        req = 4'b0100;
        run_jobs(1);

        // Worker never finishes: three watchdog expiries then nak.
        plan_job(pick(4'b1000, rr_model), 3, 1, 0);
        req = 4'b1000;
        run_jobs(1);

        // External fault in IDLE blocks the grant until it clears.
        plan_job(pick(4'b0001, rr_model), 0, 0, 2);
        ext_fault = 1'b1;
        req = 4'b0001;
        repeat (6) @(posedge clk);
        #2;
        check("fault_blocks_gnt", gnt == 0 && !active, {gnt, active}, 0);
        ext_fault = 1'b0;
        run_jobs(1);

        // Requester drops mid-job; a new request waits for IDLE.
        plan_job(2, 0, 0, 8);
        plan_job(pick(4'b0010, rr_model), 0, 0, 3);
        req = 4'b0100;
        wait_grant("drop_grant");
        repeat (3) @(posedge clk);
        #2;
        req = 4'b0010;
        run_jobs(2);

        // Asynchronous reset mid-RUN, then grant from pointer 0.
        req = 4'b0100;
        beh_q.push_back(2 * 16);
        wait_grant("reset_grant");
        repeat (4) @(posedge clk);
        #4;
        check("reset_in_run", wk_busy && gnt == 4'b0100, {wk_busy, gnt}, 5'b10100);
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt", gnt == 0 && ack == 0 && nak == 0, {gnt, ack, nak}, 0);
        check("async_rst_ctrl", {wk_start, wk_abort, timeout_evt, active} == 0, {wk_start, wk_abort, timeout_evt, active}, 0);
        beh_q.delete();
        req = 4'b1010;
        rr_model = 0;
        plan_job(pick(4'b1010, rr_model), 0, 0, 4);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_jobs(1);

        // Randomized phases.
        for (int p = 0; p < 14; p++) begin
            m  = N_REQ'($urandom_range(1, 15));
            nj = $urandom_range(1, 5);
            for (int j = 0; j < nj; j++)
                plan_job(pick(m, rr_model), $urandom_range(0, MAX_RETRY + 1), 2, 0);
            req = m;
            run_jobs(nj);
        end

        repeat (5) @(posedge clk);
        #2;
        check("exp_q_drained", exp_q.size() == 0, exp_q.size(), 0);
        check("beh_q_drained", beh_q.size() == 0, beh_q.size(), 0);
        check("timeout_count", seen_timeouts == exp_timeouts, seen_timeouts, exp_timeouts);
        check("final_idle", gnt == 0 && !active, {gnt, active}, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
